// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding IMEM fetch sequencer feeding IF/ID.
// Applies EX redirects, flushes wrong-path work, discards stale responses and absorbs stalls.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no request
// RUN   | issue fetch request at pc when IF/ID can accept
// WAIT  | request granted, waiting for the response
// HOLD  | response captured during a stall, presented from hold regs
// DRAIN | redirect left a response outstanding; discard it on arrival
// HALT  | misaligned redirect target seen; idle until reset
module pc_fetch_sequencer #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_ex_valid,
    input  logic [1:0]      i_prePCSrc,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic [XLEN-1:0] i_jalr_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_inst,
    output logic            o_flush,
    output logic            o_misalign
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_RUN   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
    logic [XLEN-1:0]   hold_inst_q, hold_inst_d;

    logic              redirect;
    logic              redirect_en;
    logic              target_misaligned;
    logic [XLEN-1:0]   jalr_aligned;
    logic [XLEN-1:0]   target;

    // jalr wins when both bits are set; its target always has bit 0 cleared.
    assign jalr_aligned      = i_jalr_target & ~XLEN'(1);
    assign target            = i_prePCSrc[1] ? jalr_aligned : i_branch_target;
    assign redirect          = i_ex_valid & (|i_prePCSrc);
    assign redirect_en       = redirect && (state_q != S_BOOT) && (state_q != S_HALT);
    assign target_misaligned = |target[1:0];

    assign o_imem_addr = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        o_imem_req  = 1'b0;
        o_if_valid  = 1'b0;
        o_if_pc     = '0;
        o_if_inst   = '0;
        o_flush     = 1'b0;
        o_misalign  = 1'b0;

        if (redirect_en) begin
            o_flush = 1'b1;
            if (target_misaligned) begin
                o_misalign = 1'b1;
                state_d    = S_HALT;
            end else begin
                pc_d = target;
                unique case (state_q)
                    S_WAIT:  state_d = i_imem_rvalid ? S_RUN : S_DRAIN;
                    S_HOLD:  state_d = S_RUN;
                    default: state_d = state_q;
                endcase
            end
        end else begin
            unique case (state_q)
                S_BOOT: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    o_imem_req = ~i_stall;
                    if (!i_stall && i_imem_gnt) begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (!i_stall) begin
                            o_if_valid = 1'b1;
                            o_if_pc    = fetch_pc_q;
                            o_if_inst  = i_imem_rdata;
                            state_d    = S_RUN;
                        end else begin
                            hold_pc_d   = fetch_pc_q;
                            hold_inst_d = i_imem_rdata;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    o_if_valid = 1'b1;
                    o_if_pc    = hold_pc_q;
                    o_if_inst  = hold_inst_q;
                    if (!i_stall) begin
                        state_d = S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (i_imem_rvalid) begin
                        state_d = S_RUN;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= '0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: granted fetches push expected {pc, inst} to a
// scoreboard that is popped and compared when the DUT presents o_if_valid.
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [1:0]  pre;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        flush;
    logic        misalign;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_pc;
    int          n_cmp;
    int          n_err;

    pc_fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_ex_valid      (ex_valid),
        .i_prePCSrc      (pre),
        .i_branch_target (btgt),
        .i_jalr_target   (jtgt),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_gnt      (gnt),
        .i_imem_rvalid   (rvalid),
        .i_imem_rdata    (rdata),
        .o_if_valid      (if_valid),
        .o_if_pc         (if_pc),
        .o_if_inst       (if_inst),
        .o_flush         (flush),
        .o_misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return {a[23:0], 8'h13} ^ 32'h5A00_0000;
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to the next falling edge with all inputs idle; caller overrides, waits #1, then checks.
    task automatic cyc();
        @(negedge clk);
        stall    = 1'b0;
        ex_valid = 1'b0;
        pre      = 2'b00;
        btgt     = '0;
        jtgt     = '0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
    endtask

    task automatic grant_cycle(input logic [31:0] inst);
        cyc();
        gnt = 1'b1;
        #1;
        chk_b("req", imem_req, 1'b1);
        chk_w("req_addr", imem_addr, exp_pc);
        sb.push_back('{pc: exp_pc, inst: inst});
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic pop_check();
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_underflow observed=empty expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk_w("if_pc", if_pc, e.pc);
            chk_w("if_inst", if_inst, e.inst);
        end
    endtask

    task automatic respond();
        cyc();
        rvalid = 1'b1;
        rdata  = (sb.size() != 0) ? sb[0].inst : 32'hBAD0_BAD0;
        #1;
        chk_b("wait_req", imem_req, 1'b0);
        chk_b("if_valid", if_valid, 1'b1);
        pop_check();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_pc   = 32'h0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        ex_valid = 1'b0;
        pre      = 2'b00;
        btgt     = '0;
        jtgt     = '0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;

        // reset state
        cyc(); #1;
        chk_b("rst_req", imem_req, 1'b0);
        chk_w("rst_addr", imem_addr, 32'h0);
        chk_b("rst_if_valid", if_valid, 1'b0);
        chk_b("rst_flush", flush, 1'b0);
        chk_b("rst_misalign", misalign, 1'b0);
        cyc(); rst_n = 1'b1; #1;
        chk_b("boot_req", imem_req, 1'b0);

        // sequential fetches 0x0, 0x4, 0x8
        for (int i = 0; i < 3; i++) begin
            grant_cycle(mk_inst(exp_pc));
            respond();
        end

        // stall during WAIT -> HOLD presents 0x13 until stall drops
        grant_cycle(32'h0000_0013);
        cyc(); stall = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0013; #1;
        chk_b("capture_valid", if_valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(); stall = 1'b1; #1;
            chk_b("hold_valid", if_valid, 1'b1);
            chk_w("hold_inst", if_inst, 32'h0000_0013);
            chk_w("hold_pc", if_pc, 32'h0000_000C);
            chk_b("hold_req", imem_req, 1'b0);
        end
        cyc(); #1;
        chk_b("hold_release", if_valid, 1'b1);
        pop_check();

        // branch redirect in WAIT, stale response two cycles later
        grant_cycle(mk_inst(exp_pc));
        cyc(); ex_valid = 1'b1; pre = 2'b01; btgt = 32'h100; jtgt = 32'h555; #1;
        chk_b("br_flush", flush, 1'b1);
        chk_b("br_if_valid", if_valid, 1'b0);
        chk_b("br_misalign", misalign, 1'b0);
        chk_b("br_req", imem_req, 1'b0);
        void'(sb.pop_front());
        exp_pc = 32'h100;
        cyc(); #1;
        chk_b("drain_flush", flush, 1'b0);
        chk_b("drain_req", imem_req, 1'b0);
        cyc(); rvalid = 1'b1; rdata = 32'hDEAD_BEEF; #1;
        chk_b("drain_discard", if_valid, 1'b0);
        grant_cycle(mk_inst(exp_pc));
        respond();

        // redirect while stalled in HOLD drops the held entry
        grant_cycle(mk_inst(exp_pc));
        cyc(); stall = 1'b1; rvalid = 1'b1; rdata = sb[0].inst; #1;
        chk_b("hold2_capture", if_valid, 1'b0);
        cyc(); stall = 1'b1; ex_valid = 1'b1; pre = 2'b01; btgt = 32'h200; #1;
        chk_b("hold_redir_flush", flush, 1'b1);
        chk_b("hold_redir_valid", if_valid, 1'b0);
        void'(sb.pop_front());
        exp_pc = 32'h200;
        cyc(); stall = 1'b1; #1;
        chk_b("stalled_run_req", imem_req, 1'b0);
        chk_b("stalled_run_valid", if_valid, 1'b0);
        grant_cycle(mk_inst(exp_pc));
        respond();

        // aligned jalr in RUN (2'b11 selects jalr, bit0 cleared)
        cyc(); ex_valid = 1'b1; pre = 2'b11; jtgt = 32'h301; btgt = 32'h400; #1;
        chk_b("jalr_req", imem_req, 1'b0);
        chk_b("jalr_flush", flush, 1'b1);
        chk_b("jalr_misalign", misalign, 1'b0);
        exp_pc = 32'h300;
        grant_cycle(mk_inst(exp_pc));
        respond();

        // pc wraps from 0xFFFFFFFC to 0
        cyc(); ex_valid = 1'b1; pre = 2'b01; btgt = 32'hFFFF_FFFC; #1;
        chk_b("wrap_flush", flush, 1'b1);
        exp_pc = 32'hFFFF_FFFC;
        grant_cycle(mk_inst(exp_pc));
        respond();
        grant_cycle(mk_inst(exp_pc));
        respond();

        // reset asserted in WAIT clears outputs immediately
        grant_cycle(mk_inst(exp_pc));
        cyc(); rvalid = 1'b1; rdata = sb[0].inst; rst_n = 1'b0; #1;
        chk_b("mid_rst_valid", if_valid, 1'b0);
        chk_w("mid_rst_addr", imem_addr, 32'h0);
        chk_b("mid_rst_req", imem_req, 1'b0);
        sb.delete();
        exp_pc = 32'h0;
        cyc(); rst_n = 1'b0; #1;
        cyc(); rst_n = 1'b1; #1;
        chk_b("reboot_req", imem_req, 1'b0);
        grant_cycle(mk_inst(exp_pc));
        respond();

        // misaligned jalr in WAIT -> HALT, outstanding response ignored
        grant_cycle(mk_inst(exp_pc));
        cyc(); ex_valid = 1'b1; pre = 2'b11; jtgt = 32'h203; btgt = 32'h100; #1;
        chk_b("mis_pulse", misalign, 1'b1);
        chk_b("mis_flush", flush, 1'b1);
        chk_b("mis_valid", if_valid, 1'b0);
        chk_b("mis_req", imem_req, 1'b0);
        void'(sb.pop_front());
        cyc(); rvalid = 1'b1; rdata = 32'h1234_5678; #1;
        chk_b("halt_valid", if_valid, 1'b0);
        chk_b("halt_misalign", misalign, 1'b0);
        chk_w("halt_pc", imem_addr, exp_pc);
        for (int i = 0; i < 4; i++) begin
            cyc(); ex_valid = 1'b1; pre = 2'b01; btgt = 32'h40; gnt = 1'b1; #1;
            chk_b("halt_req", imem_req, 1'b0);
            chk_b("halt_flush", flush, 1'b0);
            chk_b("halt_if_valid", if_valid, 1'b0);
        end

        chk_w("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
